// File: rtl/cmos_capture_ctrl.sv
// Frame sequencer for the CMOS capture path: aligns to vsync, counts pixels and lines,
// emits ping-pong frame-buffer writes and commits only geometrically good frames.
module cmos_capture_ctrl #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 20,
  parameter int BASE0    = 0,
  parameter int BASE1    = 307200
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              cmos_vsync,
  input  logic              cmos_href,
  input  logic              cmos_valid,
  input  logic [15:0]       cmos_data,
  input  logic              cap_start,
  input  logic              cap_cont,
  input  logic              cap_abort,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              rd_buf_sel,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int PIX_W  = $clog2(H_PIXELS + 2);
  localparam int LINE_W = $clog2(V_LINES + 2);

  localparam logic [PIX_W-1:0]  PIX_FULL  = PIX_W'(H_PIXELS);
  localparam logic [PIX_W-1:0]  PIX_SAT   = PIX_W'(H_PIXELS + 1);
  localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(V_LINES);
  localparam logic [LINE_W-1:0] LINE_SAT  = LINE_W'(V_LINES + 1);
  localparam logic [ADDR_W-1:0] ADDR_B0   = ADDR_W'(BASE0);
  localparam logic [ADDR_W-1:0] ADDR_B1   = ADDR_W'(BASE1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic              wr_buf_sel_q, wr_buf_sel_d;
  logic              rd_buf_sel_q, rd_buf_sel_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              line_err_q, line_err_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;

  logic              vs_rise, href_fall, pix_in_frame, frame_good;
  logic [ADDR_W-1:0] cur_base, next_base;

  assign vs_rise      = cmos_vsync & ~vsync_q;
  assign href_fall    = ~cmos_href & href_q;
  assign cur_base     = wr_buf_sel_q ? ADDR_B1 : ADDR_B0;
  assign pix_in_frame = (pix_q < PIX_FULL) && (line_q < LINE_FULL);
  assign frame_good   = (line_q == LINE_FULL) && !line_err_q;
  // A good frame hands its buffer to readout, so the next frame starts in the other one.
  assign next_base    = frame_good ? (wr_buf_sel_q ? ADDR_B0 : ADDR_B1) : cur_base;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    wr_buf_sel_d = wr_buf_sel_q;
    rd_buf_sel_d = rd_buf_sel_q;
    vsync_d      = cmos_vsync;
    href_d       = cmos_href;
    pix_d        = pix_q;
    line_d       = line_q;
    line_err_d   = line_err_q;
    line_base_d  = line_base_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (cap_abort) begin
      state_d    = ST_IDLE;
      pix_d      = '0;
      line_d     = '0;
      line_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cap_start) begin
            mode_d  = cap_cont;
            state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          if (vs_rise) begin
            state_d     = ST_CAPT;
            pix_d       = '0;
            line_d      = '0;
            line_err_d  = 1'b0;
            line_base_d = cur_base;
            addr_d      = cur_base;
          end
        end
        ST_CAPT: begin
          if (vs_rise) begin
            if (frame_good) begin
              frame_done_d = 1'b1;
              rd_buf_sel_d = wr_buf_sel_q;
              wr_buf_sel_d = ~wr_buf_sel_q;
            end else begin
              frame_err_d = 1'b1;
            end
            state_d     = mode_q ? ST_CAPT : ST_IDLE;
            pix_d       = '0;
            line_d      = '0;
            line_err_d  = 1'b0;
            line_base_d = next_base;
            addr_d      = next_base;
          end else if (href_fall) begin
            if (pix_q != PIX_FULL) line_err_d = 1'b1;
            if (line_q != LINE_SAT) line_d = line_q + 1'b1;
            pix_d = '0;
            // Re-base per line so short lines cannot skew later addresses.
            if (line_q < LINE_FULL) begin
              line_base_d = line_base_q + LINE_STEP;
              addr_d      = line_base_q + LINE_STEP;
            end
          end else if (cmos_valid) begin
            if (pix_in_frame) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = cmos_data;
              addr_d    = addr_q + 1'b1;
            end
            if (pix_q != PIX_SAT) pix_d = pix_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      wr_buf_sel_q <= 1'b0;
      rd_buf_sel_q <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      pix_q        <= '0;
      line_q       <= '0;
      line_err_q   <= 1'b0;
      line_base_q  <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      wr_buf_sel_q <= wr_buf_sel_d;
      rd_buf_sel_q <= rd_buf_sel_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      line_err_q   <= line_err_d;
      line_base_q  <= line_base_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_buf_sel = rd_buf_sel_q;
  assign busy       = (state_q == ST_ARM) || (state_q == ST_CAPT);
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Randomized bench for cmos_capture_ctrl: a frame-level model predicts every write,
// done/err pulse count and buffer selection, compared against a write monitor.
module tb_cmos_capture_ctrl;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 8;
  localparam int B0 = 0;
  localparam int B1 = 100;

  logic          cam_pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmos_vsync = 1'b0, cmos_href = 1'b0, cmos_valid = 1'b0;
  logic [15:0]   cmos_data = '0;
  logic          cap_start = 1'b0, cap_cont = 1'b0, cap_abort = 1'b0;
  logic          wr_en, rd_buf_sel, busy, frame_done, frame_err;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  always #5 cam_pclk = ~cam_pclk;

  cmos_capture_ctrl #(
    .H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .BASE0(B0), .BASE1(B1)
  ) dut (
    .cam_pclk(cam_pclk), .rst_n(rst_n),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_valid(cmos_valid),
    .cmos_data(cmos_data), .cap_start(cap_start), .cap_cont(cap_cont),
    .cap_abort(cap_abort), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_buf_sel(rd_buf_sel), .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Observed side
  logic [23:0] act_q[$];
  int act_done = 0;
  int act_err  = 0;
  always @(negedge cam_pclk) begin
    if (wr_en) act_q.push_back({wr_addr, wr_data});
    if (frame_done) act_done++;
    if (frame_err) act_err++;
  end

  // Frame-level reference model
  logic [23:0] exp_q[$];
  int exp_done = 0;
  int exp_err  = 0;
  bit m_armed, m_capt, m_mode, m_wsel, m_rsel, m_bad;
  int m_lines;

  function automatic int base_of(input bit s);
    return s ? B1 : B0;
  endfunction

  task automatic tick();
    @(posedge cam_pclk);
    #1;
  endtask

  task automatic model_clear();
    m_armed = 0; m_capt = 0; m_mode = 0; m_wsel = 0; m_rsel = 0; m_bad = 0; m_lines = 0;
    exp_done = 0; exp_err = 0; act_done = 0; act_err = 0;
    exp_q.delete(); act_q.delete();
  endtask

  task automatic do_reset();
    cmos_vsync = 0; cmos_href = 0; cmos_valid = 0; cap_start = 0; cap_abort = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    model_clear();
  endtask

  task automatic start(input bit cont);
    cap_start = 1; cap_cont = cont;
    if (!m_armed && !m_capt) begin m_armed = 1; m_mode = cont; end
    tick();
    cap_start = 0;
    tick();
  endtask

  task automatic abort();
    cap_abort = 1;
    m_armed = 0; m_capt = 0;
    tick();
    cap_abort = 0;
    tick();
  endtask

  // Frame boundary: optional pixel and/or start request on the vsync rising cycle.
  task automatic vsync(input bit pix_too, input bit start_too, input bit cont);
    bit was_idle;
    was_idle   = !m_armed && !m_capt;
    cmos_vsync = 1; cmos_valid = pix_too; cmos_data = 16'($urandom);
    cap_start  = start_too; cap_cont = cont;
    if (m_capt) begin
      if (m_lines == V && !m_bad) begin
        exp_done++; m_rsel = m_wsel; m_wsel = ~m_wsel;
      end else begin
        exp_err++;
      end
      if (!m_mode) m_capt = 0;
    end else if (m_armed) begin
      m_armed = 0; m_capt = 1;
    end
    m_lines = 0; m_bad = 0;
    if (start_too && was_idle) begin m_armed = 1; m_mode = cont; end
    tick();
    cap_start = 0; cmos_valid = 0;
    tick();
    cmos_vsync = 0;
    tick();
  endtask

  // One line of n pixels; abort_at >= 0 raises cap_abort together with that pixel.
  task automatic send_line(input int n, input int abort_at);
    cmos_href = 1;
    for (int p = 0; p < n; p++) begin
      if ($urandom_range(3) == 0) begin cmos_valid = 0; tick(); end
      cmos_valid = 1; cmos_data = 16'($urandom);
      if (p == abort_at) begin
        cap_abort = 1; m_capt = 0; m_armed = 0; m_lines = 0; m_bad = 0;
      end else if (m_capt && m_lines < V && p < H) begin
        exp_q.push_back({8'(base_of(m_wsel) + m_lines * H + p), cmos_data});
      end
      tick();
      cap_abort = 0;
    end
    cmos_valid = 0; cmos_href = 0;
    if (m_capt) begin
      if (n != H) m_bad = 1;
      m_lines++;
    end
    tick();
    tick();
  endtask

  task automatic good_frame();
    for (int l = 0; l < V; l++) send_line(H, -1);
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_nwr"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, act_q[i], exp_q[i]);
    chk({tag, "_done"}, act_done, exp_done);
    chk({tag, "_err"}, act_err, exp_err);
    chk({tag, "_rdsel"}, rd_buf_sel, m_rsel);
    chk({tag, "_busy"}, busy, m_armed || m_capt);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_rdsel"}, rd_buf_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_err"}, frame_err, 0);
  endtask

  initial begin
    model_clear();
    tick();
    tick();
    check_zero("reset");
    rst_n = 1;
    tick();

    // Single frame, with a stray start during capture that must be ignored
    start(0);
    chk("arm_busy", busy, 1);
    vsync(0, 0, 0);
    send_line(H, -1);
    start(1);
    send_line(H, -1);
    send_line(H, -1);
    vsync(0, 0, 0);
    check_frame("single");

    // Continuous: three good frames alternate buffers
    do_reset();
    start(1);
    vsync(0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      good_frame();
      vsync(0, 0, 0);
      check_frame("cont");
    end
    abort();
    chk("cont_abort_busy", busy, 0);

    // Short line then a good frame reusing base 0
    do_reset();
    start(1);
    vsync(0, 0, 0);
    send_line(H, -1); send_line(H - 1, -1); send_line(H, -1);
    vsync(0, 0, 0);
    check_frame("short");
    good_frame();
    vsync(0, 0, 0);
    check_frame("after_short");
    abort();

    // Long line and extra line
    do_reset();
    start(0);
    vsync(0, 0, 0);
    send_line(H + 2, -1);
    for (int l = 0; l < V; l++) send_line(H, -1);
    vsync(0, 0, 0);
    check_frame("long");

    // Abort on the 7th pixel of frame 2
    do_reset();
    start(1);
    vsync(0, 0, 0);
    good_frame();
    vsync(0, 0, 0);
    send_line(H, -1);
    send_line(H, 2);
    check_frame("abort");
    vsync(0, 0, 0);
    send_line(H, -1);
    check_frame("post_abort");

    // Start coincident with vsync: first frame waits for the next vsync
    do_reset();
    vsync(0, 1, 0);
    send_line(H, -1);
    check_frame("arm_wait");
    vsync(0, 0, 0);
    good_frame();
    vsync(1, 0, 0);
    check_frame("arm_frame");

    // Reset mid-line while a write is in flight
    do_reset();
    start(0);
    vsync(0, 0, 0);
    check_frame("pre_rst");
    cmos_href = 1; cmos_valid = 1; cmos_data = 16'hBEEF;
    tick();
    chk("pre_rst_wr_en", wr_en, 1);
    #1 rst_n = 0;
    #1 check_zero("mid_rst");
    cmos_href = 0; cmos_valid = 0;
    tick();
    rst_n = 1;
    tick();
    model_clear();

    // Randomized continuous run
    start(1);
    vsync(0, 0, 0);
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(1) == 0) begin
        good_frame();
      end else begin
        int nl;
        nl = $urandom_range(2, 4);
        for (int l = 0; l < nl; l++) send_line($urandom_range(3, 5), -1);
      end
      vsync(1'($urandom_range(1)), 0, 0);
      check_frame("rand");
    end
    abort();
    chk("rand_end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
